tmr_err_manager: RTL and testbench
==================================

# tmr_err_manager

- Sequential controller that sits beside the configurable TMR voter bank and consumes its per-replica error flags.
- Keeps a leaky error counter per replica and schedules resynchronisation of a replica that keeps disagreeing.
- Retires a replica into two-of-three (degraded) mode when resync fails to cure it, and raises a sticky fatal flag when voting can no longer correct.

## Interface
- N_ERR, 1: width of each voter error vector.
- CNT_W, 4: per-replica error counter width.
- THRESHOLD, 4: counter value that triggers a resync; 1..2^CNT_W-1.
- DECAY_PERIOD, 16: cycles between counter decrements; ≥2.
- MAX_RESYNC, 1: resyncs allowed per replica before it is retired.
- RESYNC_TIMEOUT, 64: cycles to wait for resync_ack_i.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- err_detected_1_i / _2_i / _3_i  in  N_ERR  replica k disagrees, per voter.
- err_corrected_i  in  N_ERR  voter corrected this cycle.
- err_detected_i  in  N_ERR  voter saw any mismatch.
- clear_i  in  1  synchronous software clear, returns the block to NORMAL.
- resync_ack_i  in  1  replica resync completed.
- resync_req_o  out  1  resync request; held until acked or timed out.
- resync_id_o  out  2  replica under resync, 0..2.
- only_two_o  out  1  drive voter only_two mode.
- excluded_o  out  3  one-hot retired replica.
- fatal_o  out  1  uncorrectable error; sticky.
- state_o  out  2  NORMAL=0, RESYNC=1, DEGRADED=2, FAIL=3.

## Operation
- Error events:
  - hit[k] = |err_detected_{k+1}_i.
  - unc = |(err_detected_i & ~err_corrected_i).
- Counters cnt[k], CNT_W bits:
  - +1 on hit[k], saturating at all-ones.
  - −1 on a decay tick, floor 0. A decay tick occurs once every DECAY_PERIOD cycles from a free-running counter.
  - hit and decay tick in the same cycle: no change.
  - Counters are frozen in RESYNC and FAIL.
  - Retired replica: its counter is cleared and held at 0.
- Attempt counter att[k] increments on each resync ack or timeout.
- FSM, reset to NORMAL:
  - NORMAL → FAIL on unc.
  - NORMAL → RESYNC when the next value of any cnt[k] ≥ THRESHOLD. Lowest k wins; other qualifying replicas are handled after returning.
  - Entering RESYNC: resync_id_o=k, resync_req_o=1, timeout counter loaded.
  - RESYNC on resync_ack_i: cnt[k]=0, att[k]+1. Goes to DEGRADED with excluded_o[k]=1 and only_two_o=1 if the new att[k] > MAX_RESYNC; otherwise back to NORMAL.
  - RESYNC on timeout with no ack: treated as exhausted; goes to DEGRADED excluding k.
  - RESYNC → FAIL on unc; FAIL has priority over ack.
  - DEGRADED → FAIL on any |err_detected_i (two replicas cannot outvote).
  - FAIL: fatal_o=1 and resync_req_o=0; stays until rst_i or clear_i.
- clear_i, any state, highest priority below rst_i:
  - Clears cnt, att, excluded_o, only_two_o and fatal_o; goes to NORMAL.
- Hits from an excluded replica are ignored.

## Timing
- All outputs are registered.
- Reset values: resync_req_o=0, resync_id_o=0, only_two_o=0, excluded_o=0, fatal_o=0, state_o=0. All counters are 0.
- Error sampled at edge t:
  - The counter shows the new value after t.
  - resync_req_o is high after the same edge t when the update reaches THRESHOLD.
- resync_ack_i is sampled only while resync_req_o=1; an ack at any other time is ignored.
- resync_req_o drops after the edge that samples the ack; the next request is possible 1 cycle later at the earliest.
- Timeout fires when the ack is still absent at the RESYNC_TIMEOUT-th edge after entry.
- unc at edge t → fatal_o=1 after t.
- rst_i mid-resync: resync_req_o drops asynchronously.

## Configuration
- TMR_ERR_MGR_DECAY_EN defined: leaky decay as described.
- TMR_ERR_MGR_DECAY_EN undefined: no decay logic. Counters only increment, and clear on resync, on clear_i, or on reset. DECAY_PERIOD is ignored.

## Test plan
- Defaults assumed: THRESHOLD=4, DECAY_PERIOD=16, MAX_RESYNC=1.
- Resync scheduling: 4 consecutive hits on replica 2 → resync_req_o=1, resync_id_o=1 after the 4th edge. Ack 3 cycles later → cnt[1]=0, state NORMAL.
- Decay: one hit on replica 1 every 20 cycles for 200 cycles with decay built in → no resync; cnt[0] ≤1. Without the macro → resync after the 4th hit.
- Retirement: replica 3 reaches threshold twice, both acked → after the second ack excluded_o=3'b100, only_two_o=1, state 2. Further err_detected_i=1 → fatal_o=1, state 3.
- Timeout: request with no ack for 64 cycles → state DEGRADED, excluded_o one-hot on resync_id_o.
- Uncorrectable: err_detected_i=1 with err_corrected_i=0 in NORMAL → fatal_o=1 next edge. An ack in the same cycle during RESYNC → FAIL still wins. clear_i → all outputs back to reset values.
- Tie and reset: replicas 1 and 3 reach threshold on the same edge → resync_id_o=0 first, then 2. rst_i pulsed mid-RESYNC → resync_req_o=0 immediately, state 0.

Source files
------------

// File: rtl/tmr_err_manager.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tmr_err_manager: leaky per-replica error counters, resync scheduling,    |
// | replica retirement and sticky fatal flag beside a TMR voter bank.        |
// | Optional decay logic: TMR_ERR_MGR_DECAY_EN.                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tmr_err_manager #(
    parameter int N_ERR          = 1,
    parameter int CNT_W          = 4,
    parameter int THRESHOLD      = 4,
    parameter int DECAY_PERIOD   = 16,
    parameter int MAX_RESYNC     = 1,
    parameter int RESYNC_TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_ERR-1:0] err_detected_1_i,
    input  logic [N_ERR-1:0] err_detected_2_i,
    input  logic [N_ERR-1:0] err_detected_3_i,
    input  logic [N_ERR-1:0] err_corrected_i,
    input  logic [N_ERR-1:0] err_detected_i,
    input  logic             clear_i,
    input  logic             resync_ack_i,
    output logic             resync_req_o,
    output logic [1:0]       resync_id_o,
    output logic             only_two_o,
    output logic [2:0]       excluded_o,
    output logic             fatal_o,
    output logic [1:0]       state_o
);

    localparam logic [1:0] S_NORMAL   = 2'd0;
    localparam logic [1:0] S_RESYNC   = 2'd1;
    localparam logic [1:0] S_DEGRADED = 2'd2;
    localparam logic [1:0] S_FAIL     = 2'd3;

    localparam int TMO_W = $clog2(RESYNC_TIMEOUT + 1);
    localparam int ATT_W = $clog2(MAX_RESYNC + 2);

    localparam logic [CNT_W-1:0] C_THRESHOLD  = CNT_W'(THRESHOLD);
    localparam logic [ATT_W-1:0] C_MAX_RESYNC = ATT_W'(MAX_RESYNC);
    localparam logic [TMO_W-1:0] C_TMO_LOAD   = TMO_W'(RESYNC_TIMEOUT - 1);

    logic [1:0]             state_q, state_d;
    logic                   req_q, req_d;
    logic [1:0]             id_q, id_d;
    logic                   two_q, two_d;
    logic [2:0]             excl_q, excl_d;
    logic                   fatal_q, fatal_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [2:0][CNT_W-1:0]  cnt_q, cnt_d, cnt_upd;
    logic [2:0][ATT_W-1:0]  att_q, att_d;

    logic [2:0]             hit;
    logic                   unc;
    logic                   dec_tick;
    logic [2:0]             qual;
    logic                   any_qual;
    logic [1:0]             sel;
    logic [ATT_W-1:0]       att_nxt;
    logic                   exhausted;

    assign hit = {|err_detected_3_i, |err_detected_2_i, |err_detected_1_i} & ~excl_q;
    assign unc = |(err_detected_i & ~err_corrected_i);

`ifdef TMR_ERR_MGR_DECAY_EN
    localparam int DEC_W = $clog2(DECAY_PERIOD);
    localparam logic [DEC_W-1:0] C_DEC_LAST = DEC_W'(DECAY_PERIOD - 1);

    logic [DEC_W-1:0] dec_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                    dec_q <= '0;
        else if (dec_q == C_DEC_LAST) dec_q <= '0;
        else                          dec_q <= dec_q + DEC_W'(1);
    end

    assign dec_tick = (dec_q == C_DEC_LAST);
`else
    // No decay in this build: constant false for any legal DECAY_PERIOD.
    assign dec_tick = (DECAY_PERIOD < 0);
`endif

    always_comb begin
        cnt_upd  = cnt_q;
        qual     = '0;
        any_qual = 1'b0;
        sel      = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (excl_q[k])
                cnt_upd[k] = '0;
            else if (hit[k] && !dec_tick && cnt_q[k] != '1)
                cnt_upd[k] = cnt_q[k] + CNT_W'(1);
            else if (dec_tick && !hit[k] && cnt_q[k] != '0)
                cnt_upd[k] = cnt_q[k] - CNT_W'(1);
            qual[k] = (cnt_upd[k] >= C_THRESHOLD);
        end
        // Lowest-numbered qualifying replica is served first.
        for (int k = 2; k >= 0; k--) begin
            if (qual[k]) begin
                sel      = 2'(k);
                any_qual = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        id_d      = id_q;
        two_d     = two_q;
        excl_d    = excl_q;
        fatal_d   = fatal_q;
        tmo_d     = tmo_q;
        cnt_d     = cnt_q;
        att_d     = att_q;
        att_nxt   = '0;
        exhausted = 1'b0;

        case (state_q)
            S_NORMAL: begin
                cnt_d = cnt_upd;
                if (unc) begin
                    state_d = S_FAIL;
                    fatal_d = 1'b1;
                end else if (any_qual) begin
                    state_d = S_RESYNC;
                    req_d   = 1'b1;
                    id_d    = sel;
                    tmo_d   = C_TMO_LOAD;
                end
            end
            S_RESYNC: begin
                if (unc) begin
                    state_d = S_FAIL;
                    fatal_d = 1'b1;
                    req_d   = 1'b0;
                end else if ((resync_ack_i && req_q) || tmo_q == '0) begin
                    // Ack or timeout both consume one attempt; a timeout always retires.
                    req_d = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        if (id_q == 2'(k)) begin
                            att_nxt   = att_q[k] + ATT_W'(1);
                            att_d[k]  = att_nxt;
                            cnt_d[k]  = '0;
                            exhausted = !resync_ack_i || (att_nxt > C_MAX_RESYNC);
                            excl_d[k] = excl_q[k] | exhausted;
                        end
                    end
                    if (exhausted) begin
                        state_d = S_DEGRADED;
                        two_d   = 1'b1;
                    end else begin
                        state_d = S_NORMAL;
                    end
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            S_DEGRADED: begin
                cnt_d = cnt_upd;
                if (|err_detected_i) begin
                    state_d = S_FAIL;
                    fatal_d = 1'b1;
                end
            end
            default: begin
                req_d   = 1'b0;
                fatal_d = 1'b1;
            end
        endcase

        if (clear_i) begin
            state_d = S_NORMAL;
            req_d   = 1'b0;
            id_d    = 2'd0;
            two_d   = 1'b0;
            excl_d  = '0;
            fatal_d = 1'b0;
            tmo_d   = '0;
            cnt_d   = '0;
            att_d   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_NORMAL;
            req_q   <= 1'b0;
            id_q    <= 2'd0;
            two_q   <= 1'b0;
            excl_q  <= '0;
            fatal_q <= 1'b0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            att_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            id_q    <= id_d;
            two_q   <= two_d;
            excl_q  <= excl_d;
            fatal_q <= fatal_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            att_q   <= att_d;
        end
    end

    assign resync_req_o = req_q;
    assign resync_id_o  = id_q;
    assign only_two_o   = two_q;
    assign excluded_o   = excl_q;
    assign fatal_o      = fatal_q;
    assign state_o      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_tmr_err_manager.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tmr_err_manager: scoreboard bench for tmr_err_manager.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_tmr_err_manager;

    localparam logic [1:0] ST_N = 2'd0;
    localparam logic [1:0] ST_R = 2'd1;
    localparam logic [1:0] ST_D = 2'd2;
    localparam logic [1:0] ST_F = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [0:0] e1 = '0, e2 = '0, e3 = '0, det = '0, cor = '0;
    logic       clr = 1'b0, ack = 1'b0;
    logic       req_o, two_o, fatal_o;
    logic [1:0] id_o, st_o;
    logic [2:0] excl_o;
    logic [9:0] act;

    tmr_err_manager dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .err_detected_1_i (e1),
        .err_detected_2_i (e2),
        .err_detected_3_i (e3),
        .err_corrected_i  (cor),
        .err_detected_i   (det),
        .clear_i          (clr),
        .resync_ack_i     (ack),
        .resync_req_o     (req_o),
        .resync_id_o      (id_o),
        .only_two_o       (two_o),
        .excluded_o       (excl_o),
        .fatal_o          (fatal_o),
        .state_o          (st_o)
    );

    always #5 clk = ~clk;

    assign act = {req_o, id_o, two_o, excl_o, fatal_o, st_o};

    typedef struct packed {
        logic [9:0] v;
        int         due;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    exp_t  head;
    string hname;

    function automatic logic [9:0] E(input logic r, input logic [1:0] id, input logic two,
                                     input logic [2:0] ex, input logic fat, input logic [1:0] st);
        return {r, id, two, ex, fat, st};
    endfunction

    task automatic check(input string nm, input logic [9:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got {req,id,two,excl,fatal,st}=%b want %b", nm, act, want);
        end
    endtask

    // Monitor: compares outputs 1 time unit after each edge against due entries.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            head  = exp_q.pop_front();
            hname = nm_q.pop_front();
            check(hname, head.v);
        end
    end

    task automatic step(input logic [2:0] h, input logic d, input logic c, input logic a,
                        input logic cl, input bit chk, input logic [9:0] want, input string nm);
        exp_t x;
        e1 = h[0]; e2 = h[1]; e3 = h[2];
        det = d; cor = c; ack = a; clr = cl;
        if (chk) begin
            x.v   = want;
            x.due = cyc + 1;
            exp_q.push_back(x);
            nm_q.push_back(nm);
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit chk, input logic [9:0] want, input string nm);
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, chk, want, nm);
    endtask

    // Reset asserts asynchronously; outputs must be at reset values before any edge.
    task automatic do_reset(input string nm);
        e1 = '0; e2 = '0; e3 = '0; det = '0; cor = '0; ack = 1'b0; clr = 1'b0;
        rst = 1'b1;
        #2;
        check(nm, E(0, 0, 0, 3'b000, 0, ST_N));
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);

        // Resync scheduling on replica 2, ack three cycles after the request.
        do_reset("reset_values");
        step(3'b000, 0, 0, 1, 0, 1, E(0, 0, 0, 3'b000, 0, ST_N), "ack_ignored_normal");
        for (int i = 0; i < 4; i++)
            step(3'b010, 0, 0, 0, 0, 1,
                 (i < 3) ? E(0, 0, 0, 3'b000, 0, ST_N) : E(1, 1, 0, 3'b000, 0, ST_R), "r2_hits");
        idle(1, E(1, 1, 0, 3'b000, 0, ST_R), "r2_req_held");
        idle(1, E(1, 1, 0, 3'b000, 0, ST_R), "r2_req_held");
        step(3'b000, 0, 0, 1, 0, 1, E(0, 1, 0, 3'b000, 0, ST_N), "r2_ack");
        for (int i = 0; i < 3; i++)
            step(3'b010, 0, 0, 0, 0, 1, E(0, 1, 0, 3'b000, 0, ST_N), "r2_cnt_cleared");

        // Retirement of replica 3 after its second acked resync.
        do_reset("reset_retire");
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++)
                step(3'b100, 0, 0, 0, 0, 1,
                     (i < 3) ? E(0, (r == 0) ? 2'd0 : 2'd2, 0, 3'b000, 0, ST_N)
                             : E(1, 2, 0, 3'b000, 0, ST_R), "r3_hits");
            step(3'b000, 0, 0, 1, 0, 1,
                 (r == 0) ? E(0, 2, 0, 3'b000, 0, ST_N) : E(0, 2, 1, 3'b100, 0, ST_D), "r3_ack");
        end
        step(3'b100, 0, 0, 0, 0, 1, E(0, 2, 1, 3'b100, 0, ST_D), "excluded_hit_ignored");
        step(3'b000, 1, 1, 0, 0, 1, E(0, 2, 1, 3'b100, 1, ST_F), "degraded_err_fatal");
        idle(1, E(0, 2, 1, 3'b100, 1, ST_F), "fatal_sticky");
        step(3'b000, 0, 0, 0, 1, 1, E(0, 0, 0, 3'b000, 0, ST_N), "clear_from_fatal");

        // Timeout: no ack for RESYNC_TIMEOUT edges retires the replica.
        do_reset("reset_timeout");
        for (int i = 0; i < 4; i++)
            step(3'b001, 0, 0, 0, 0, (i == 3), E(1, 0, 0, 3'b000, 0, ST_R), "r1_req");
        for (int i = 1; i <= 64; i++)
            idle(i >= 63, (i == 64) ? E(0, 0, 1, 3'b001, 0, ST_D) : E(1, 0, 0, 3'b000, 0, ST_R),
                 (i == 64) ? "tmo_degraded" : "tmo_not_yet");

        // Uncorrectable errors, clear, and unc winning over a same-cycle ack.
        do_reset("reset_unc");
        step(3'b000, 1, 1, 0, 0, 1, E(0, 0, 0, 3'b000, 0, ST_N), "corrected_ok");
        step(3'b000, 1, 0, 0, 0, 1, E(0, 0, 0, 3'b000, 1, ST_F), "unc_fatal");
        step(3'b000, 0, 0, 0, 1, 1, E(0, 0, 0, 3'b000, 0, ST_N), "clear_all");
        for (int i = 0; i < 4; i++)
            step(3'b001, 0, 0, 0, 0, (i == 3), E(1, 0, 0, 3'b000, 0, ST_R), "r1_req_again");
        step(3'b000, 1, 0, 1, 0, 1, E(0, 0, 0, 3'b000, 1, ST_F), "unc_beats_ack");

        // Tie between replicas 1 and 3, then asynchronous reset mid-resync.
        do_reset("reset_tie");
        for (int i = 0; i < 4; i++)
            step(3'b101, 0, 0, 0, 0, 1,
                 (i < 3) ? E(0, 0, 0, 3'b000, 0, ST_N) : E(1, 0, 0, 3'b000, 0, ST_R), "tie_lowest");
        step(3'b000, 0, 0, 1, 0, 1, E(0, 0, 0, 3'b000, 0, ST_N), "tie_ack0");
        idle(1, E(1, 2, 0, 3'b000, 0, ST_R), "tie_second");
        do_reset("rst_async_mid_resync");

        // Decay: one hit on replica 1 every 20 cycles.
`ifdef TMR_ERR_MGR_DECAY_EN
        for (int n = 0; n < 10; n++) begin
            step(3'b001, 0, 0, 0, 0, 1, E(0, 0, 0, 3'b000, 0, ST_N), "decay_no_resync");
            for (int c = 1; c < 20; c++) idle(0, '0, "");
        end
`else
        for (int n = 0; n < 4; n++) begin
            step(3'b001, 0, 0, 0, 0, 1,
                 (n < 3) ? E(0, 0, 0, 3'b000, 0, ST_N) : E(1, 0, 0, 3'b000, 0, ST_R), "nodecay_hits");
            for (int c = 1; c < 20; c++) idle(0, '0, "");
        end
        step(3'b000, 0, 0, 1, 0, 1, E(0, 0, 0, 3'b000, 0, ST_N), "nodecay_ack");
`endif

        repeat (3) idle(0, '0, "");
        while (exp_q.size() > 0) begin
            head  = exp_q.pop_front();
            hname = nm_q.pop_front();
            total++;
            bad++;
            $display("FAIL %s: got no sample want %b", hname, head.v);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
